// File: rtl/tcm_mem_lat.sv
// rtl/tcm_mem_lat.sv - dual-port (fetch + data) 64-bit TCM with fixed RD_LAT response pipeline
// Optional random accept stalls from a 16-bit LFSR when TCM_MEM_STALL_EN is defined.
module tcm_mem_lat #(
    parameter int          MEM_AW    = 17,
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [63:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic [31:0] mem_d_data_rd_o,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [10:0] mem_d_resp_tag_o
);
    localparam int IW    = MEM_AW - 3;
    localparam int WORDS = 2 ** IW;

    logic [63:0] mem_q [WORDS];

    logic        i_vld_q [RD_LAT];
    logic        i_err_q [RD_LAT];
    logic [63:0] i_dat_q [RD_LAT];
    logic        i_vld_d [RD_LAT];
    logic        i_err_d [RD_LAT];
    logic [63:0] i_dat_d [RD_LAT];
    logic        d_vld_q [RD_LAT];
    logic        d_err_q [RD_LAT];
    logic [31:0] d_dat_q [RD_LAT];
    logic [10:0] d_tag_q [RD_LAT];
    logic        d_vld_d [RD_LAT];
    logic        d_err_d [RD_LAT];
    logic [31:0] d_dat_d [RD_LAT];
    logic [10:0] d_tag_d [RD_LAT];

    logic        i_acc, d_acc;
    logic [31:0] i_off, d_off;
    logic        i_hit, d_hit, i_fire, d_fire, d_op, d_we;
    logic [IW-1:0] i_idx, d_idx;
    logic [63:0] d_word, d_wdata;
    logic [7:0]  d_be;

`ifdef TCM_MEM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    assign i_acc = ~rst_i & ~lfsr_q[1];
    assign d_acc = ~rst_i & ~lfsr_q[0];
`else
    assign i_acc = ~rst_i;
    assign d_acc = ~rst_i;
`endif

    always_comb begin
        i_off   = mem_i_pc_i - BASE_ADDR;
        d_off   = mem_d_addr_i - BASE_ADDR;
        i_hit   = (i_off >> MEM_AW) == 32'd0;
        d_hit   = (d_off >> MEM_AW) == 32'd0;
        i_idx   = i_off[MEM_AW-1:3];
        d_idx   = d_off[MEM_AW-1:3];
        i_fire  = mem_i_rd_i & i_acc;
        d_op    = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
        d_fire  = d_op & d_acc;
        d_we    = d_fire & d_hit & (|mem_d_wr_i);
        d_word  = mem_q[d_idx];
        d_wdata = {mem_d_data_wr_i, mem_d_data_wr_i};
        d_be    = d_off[2] ? {mem_d_wr_i, 4'b0000} : {4'b0000, mem_d_wr_i};
    end

    // Stage 0 captures the read made in the accept cycle, so same-cycle writes are not visible.
    always_comb begin
        i_vld_d[0] = i_fire;
        i_err_d[0] = i_fire & ~i_hit;
        i_dat_d[0] = (i_fire & i_hit) ? mem_q[i_idx] : 64'd0;
        d_vld_d[0] = d_fire;
        d_err_d[0] = d_fire & ~d_hit;
        d_dat_d[0] = (d_fire & d_hit & mem_d_rd_i) ? (d_off[2] ? d_word[63:32] : d_word[31:0]) : 32'd0;
        d_tag_d[0] = d_fire ? mem_d_req_tag_i : 11'd0;
        for (int s = 1; s < RD_LAT; s++) begin
            i_vld_d[s] = i_vld_q[s-1];
            i_err_d[s] = i_err_q[s-1];
            i_dat_d[s] = i_dat_q[s-1];
            d_vld_d[s] = d_vld_q[s-1];
            d_err_d[s] = d_err_q[s-1];
            d_dat_d[s] = d_dat_q[s-1];
            d_tag_d[s] = d_tag_q[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < RD_LAT; s++) begin
            if (rst_i) begin
                i_vld_q[s] <= 1'b0;
                i_err_q[s] <= 1'b0;
                i_dat_q[s] <= 64'd0;
                d_vld_q[s] <= 1'b0;
                d_err_q[s] <= 1'b0;
                d_dat_q[s] <= 32'd0;
                d_tag_q[s] <= 11'd0;
            end else begin
                i_vld_q[s] <= i_vld_d[s];
                i_err_q[s] <= i_err_d[s];
                i_dat_q[s] <= i_dat_d[s];
                d_vld_q[s] <= d_vld_d[s];
                d_err_q[s] <= d_err_d[s];
                d_dat_q[s] <= d_dat_d[s];
                d_tag_q[s] <= d_tag_d[s];
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (d_we) begin
            for (int b = 0; b < 8; b++) begin
                if (d_be[b]) mem_q[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    assign mem_i_accept_o   = i_acc;
    assign mem_d_accept_o   = d_acc;
    assign mem_i_valid_o    = ~rst_i & i_vld_q[RD_LAT-1];
    assign mem_i_error_o    = ~rst_i & i_err_q[RD_LAT-1];
    assign mem_i_inst_o     = rst_i ? 64'd0 : i_dat_q[RD_LAT-1];
    assign mem_d_ack_o      = ~rst_i & d_vld_q[RD_LAT-1];
    assign mem_d_error_o    = ~rst_i & d_err_q[RD_LAT-1];
    assign mem_d_data_rd_o  = rst_i ? 32'd0 : d_dat_q[RD_LAT-1];
    assign mem_d_resp_tag_o = rst_i ? 11'd0 : d_tag_q[RD_LAT-1];

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i,
                         i_off[2:0], d_off[1:0]};
endmodule

// File: tb/tb_tcm_mem_lat.sv
// tb/tb_tcm_mem_lat.sv - self-checking bench for tcm_mem_lat with a cycle-slot response scoreboard
module tb_tcm_mem_lat;
    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_i_rd_i = 0, mem_i_flush_i = 0, mem_i_invalidate_i = 0;
    logic [31:0] mem_i_pc_i = 0;
    logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [63:0] mem_i_inst_o;
    logic [31:0] mem_d_addr_i = 0, mem_d_data_wr_i = 0;
    logic        mem_d_rd_i = 0, mem_d_cacheable_i = 0;
    logic [3:0]  mem_d_wr_i = 0;
    logic [10:0] mem_d_req_tag_i = 0;
    logic        mem_d_invalidate_i = 0, mem_d_writeback_i = 0, mem_d_flush_i = 0;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    always #5 clk = ~clk;

    tcm_mem_lat #(.MEM_AW(17), .BASE_ADDR(BASE), .RD_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i),
        .mem_i_invalidate_i(mem_i_invalidate_i), .mem_i_pc_i(mem_i_pc_i),
        .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o),
        .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
        .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
        .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i),
        .mem_d_cacheable_i(mem_d_cacheable_i), .mem_d_req_tag_i(mem_d_req_tag_i),
        .mem_d_invalidate_i(mem_d_invalidate_i), .mem_d_writeback_i(mem_d_writeback_i),
        .mem_d_flush_i(mem_d_flush_i), .mem_d_data_rd_o(mem_d_data_rd_o),
        .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o),
        .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit d_acc_seen = 0;

    // Expected responses indexed by the cycle they must appear in (mod 16).
    bit          e_iv [16];
    bit          e_ie [16];
    logic [63:0] e_id [16];
    bit          e_dv [16];
    bit          e_de [16];
    logic [31:0] e_dd [16];
    logic [10:0] e_dt [16];

    // Model of the first 32 words of memory; stimulus stays inside this window.
    logic [63:0] mm [32];

`ifdef TCM_MEM_STALL_EN
    logic [15:0] tb_lfsr = 16'hACE1;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o < 32'h20000;
    endfunction

    task automatic step();
        int s, ns;
        bit ea_i, ea_d, ifire, dfire;
        logic [31:0] off;
        logic [63:0] w;
        @(negedge clk);
        s  = cyc % 16;
        ns = (cyc + LAT) % 16;
`ifdef TCM_MEM_STALL_EN
        ea_i = ~tb_lfsr[1];
        ea_d = ~tb_lfsr[0];
`else
        ea_i = 1'b1;
        ea_d = 1'b1;
`endif
        d_acc_seen = 0;
        if (rst_i) begin
            for (int k = 0; k < 16; k++) begin
                e_iv[k] = 0;
                e_dv[k] = 0;
            end
            chk("rst_i_accept", {63'd0, mem_i_accept_o}, 64'd0);
            chk("rst_d_accept", {63'd0, mem_d_accept_o}, 64'd0);
            chk("rst_i_valid", {63'd0, mem_i_valid_o}, 64'd0);
            chk("rst_d_ack", {63'd0, mem_d_ack_o}, 64'd0);
            chk("rst_outs", {mem_i_inst_o ^ {mem_d_data_rd_o, 21'd0, mem_d_resp_tag_o}},
                64'd0);
            chk("rst_errs", {62'd0, mem_i_error_o, mem_d_error_o}, 64'd0);
        end else begin
            chk("i_accept", {63'd0, mem_i_accept_o}, {63'd0, ea_i});
            chk("d_accept", {63'd0, mem_d_accept_o}, {63'd0, ea_d});
            chk("i_valid", {63'd0, mem_i_valid_o}, {63'd0, e_iv[s]});
            if (e_iv[s]) begin
                chk("i_inst", mem_i_inst_o, e_id[s]);
                chk("i_error", {63'd0, mem_i_error_o}, {63'd0, e_ie[s]});
            end
            chk("d_ack", {63'd0, mem_d_ack_o}, {63'd0, e_dv[s]});
            if (e_dv[s]) begin
                chk("d_data", {32'd0, mem_d_data_rd_o}, {32'd0, e_dd[s]});
                chk("d_error", {63'd0, mem_d_error_o}, {63'd0, e_de[s]});
                chk("d_tag", {53'd0, mem_d_resp_tag_o}, {53'd0, e_dt[s]});
            end
            e_iv[s] = 0;
            e_dv[s] = 0;
            ifire = mem_i_rd_i & ea_i;
            if (ifire) begin
                off      = mem_i_pc_i - BASE;
                e_iv[ns] = 1;
                e_ie[ns] = !in_rng(mem_i_pc_i);
                e_id[ns] = in_rng(mem_i_pc_i) ? mm[off[7:3]] : 64'd0;
            end
            dfire = (mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i |
                     mem_d_flush_i) & ea_d;
            if (dfire) begin
                off      = mem_d_addr_i - BASE;
                e_dv[ns] = 1;
                e_dt[ns] = mem_d_req_tag_i;
                e_de[ns] = !in_rng(mem_d_addr_i);
                e_dd[ns] = 32'd0;
                if (in_rng(mem_d_addr_i)) begin
                    w = mm[off[7:3]];
                    if (mem_d_rd_i) e_dd[ns] = off[2] ? w[63:32] : w[31:0];
                    for (int b = 0; b < 4; b++)
                        if (mem_d_wr_i[b])
                            mm[off[7:3]][(off[2] ? 32 : 0) + 8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
                end
            end
            d_acc_seen = dfire;
        end
        cyc++;
        @(posedge clk);
`ifdef TCM_MEM_STALL_EN
        tb_lfsr = rst_i ? 16'hACE1
                        : {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
`endif
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // maint bits: [0] invalidate, [1] writeback, [2] flush
    task automatic d_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wr,
                         input bit rd, input logic [2:0] maint, input logic [10:0] tag);
        mem_d_addr_i       = a;
        mem_d_data_wr_i    = wd;
        mem_d_wr_i         = wr;
        mem_d_rd_i         = rd;
        mem_d_invalidate_i = maint[0];
        mem_d_writeback_i  = maint[1];
        mem_d_flush_i      = maint[2];
        mem_d_req_tag_i    = tag;
        mem_d_cacheable_i  = 1'($urandom);
        for (int k = 0; k < 64; k++) begin
            step();
            if (d_acc_seen) break;
        end
        if (!d_acc_seen) begin
            $display("FAIL d_req_timeout addr=%h not accepted within 64 cycles", a);
            $fatal(1);
        end
        mem_d_wr_i = 0; mem_d_rd_i = 0;
        mem_d_invalidate_i = 0; mem_d_writeback_i = 0; mem_d_flush_i = 0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  st;
        int          op;
        idle(3);
        rst_i = 0;
        idle(2);

        for (int w = 0; w < 32; w++) begin
            d_req(BASE + 32'(w*8),     $urandom, 4'hF, 0, 3'd0, 11'(w));
            d_req(BASE + 32'(w*8 + 4), $urandom, 4'hF, 0, 3'd0, 11'(w + 100));
        end
        idle(LAT);

        d_req(32'h80000010, 32'hDEADBEEF, 4'hF, 0, 3'd0, 11'd5);
        d_req(32'h80000010, 32'd0, 4'h0, 1, 3'd0, 11'd6);
        d_req(32'h80000024, 32'h11223344, 4'hF, 0, 3'd0, 11'd7);
        d_req(32'h80000024, 32'h0000AB00, 4'b0010, 0, 3'd0, 11'd8);
        d_req(32'h80000027, 32'd0, 4'h0, 1, 3'd0, 11'd9);
        d_req(32'h80000024, 32'h55667788, 4'hF, 1, 3'd0, 11'd10);
        d_req(32'h80000024, 32'd0, 4'h0, 1, 3'd4, 11'd11);
        d_req(32'h80000030, 32'd0, 4'h0, 0, 3'd3, 11'd12);
        idle(LAT);

        d_req(32'h7FFFFFFC, 32'd0, 4'h0, 1, 3'd0, 11'd20);
        d_req(32'h80020000, 32'd0, 4'h0, 1, 3'd0, 11'd21);
        d_req(32'h80020000, 32'hFFFFFFFF, 4'hF, 0, 3'd0, 11'd22);
        d_req(32'h80000000, 32'd0, 4'h0, 1, 3'd0, 11'd23);
        idle(LAT);

        for (int t = 1; t <= 8; t++) d_req(BASE + 32'(t*4), 32'd0, 4'h0, 1, 3'd0, 11'(t));
        mem_i_pc_i = BASE;
        mem_i_rd_i = 1;
        step();
        mem_i_rd_i = 0;
        idle(LAT);

        mem_i_pc_i = BASE + 32'h8;
        mem_i_rd_i = 1;
        d_req(BASE + 32'h8, 32'hCAFEF00D, 4'hF, 0, 3'd0, 11'd30);
        step();
        mem_i_rd_i = 0;
        idle(LAT);

        d_req(BASE + 32'h40, 32'd0, 4'h0, 1, 3'd0, 11'h11);
        d_req(BASE + 32'h44, 32'd0, 4'h0, 1, 3'd0, 11'h12);
        rst_i = 1;
        idle(3);
        rst_i = 0;
        d_req(BASE + 32'h48, 32'd0, 4'h0, 1, 3'd0, 11'h13);
        idle(LAT + 1);

        for (int n = 0; n < 1000; n++) begin
            mem_i_rd_i         = 1'($urandom);
            mem_i_pc_i         = BASE + ($urandom % 256);
            mem_i_flush_i      = ($urandom % 8) == 0;
            mem_i_invalidate_i = ($urandom % 8) == 0;
            a  = BASE + ($urandom % 256);
            if (($urandom % 16) == 0)
                a = (($urandom % 2) == 0) ? (32'h80020000 | ($urandom % 256)) : (32'h7FFFFF00 + ($urandom % 256));
            st = 4'(($urandom % 15) + 1);
            op = int'($urandom % 4);
            case (op)
                0: d_req(a, $urandom, 4'h0, 1, 3'd0, 11'($urandom));
                1: d_req(a, $urandom, st, 0, 3'd0, 11'($urandom));
                2: d_req(a, $urandom, st, 1, 3'd0, 11'($urandom));
                default: d_req(a, $urandom, 4'h0, 0, 3'(($urandom % 7) + 1), 11'($urandom));
            endcase
        end
        mem_i_rd_i = 0; mem_i_flush_i = 0; mem_i_invalidate_i = 0;
        idle(LAT + 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
